// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - decode-to-execute pipeline register with stall, flush and bubble counter
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              valid_d,
  input  logic              reg_write_d,
  input  logic [1:0]        result_src_d,
  input  logic              mem_write_d,
  input  logic              alu_src_d,
  input  logic [2:0]        alu_op_d,
  input  logic              branch_d,
  input  logic              jump_d,
  input  logic [2:0]        funct3_d,
  input  logic              funct7b5_d,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rd_d,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic [DATA_W-1:0] pc_d,
  input  logic [DATA_W-1:0] pc_plus4_d,
  input  logic [DATA_W-1:0] imm_ext_d,
  output logic              valid_e,
  output logic              reg_write_e,
  output logic [1:0]        result_src_e,
  output logic              mem_write_e,
  output logic              alu_src_e,
  output logic [2:0]        alu_op_e,
  output logic              branch_e,
  output logic              jump_e,
  output logic [2:0]        funct3_e,
  output logic              funct7b5_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic [DATA_W-1:0] rd1_e,
  output logic [DATA_W-1:0] rd2_e,
  output logic [DATA_W-1:0] pc_e,
  output logic [DATA_W-1:0] pc_plus4_e,
  output logic [DATA_W-1:0] imm_ext_e,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clear_e;      // load an all-zero bubble
  logic load_e;       // accept the decode slot
  logic count_bubble; // this edge puts a bubble into EX
  logic rd_nonzero;

  // Decide what the next edge does; reset is handled inside the registers.
  always_comb begin
    clear_e      = flush_e;
    load_e       = !flush_e && !stall_e;
    count_bubble = flush_e || (!stall_e && !valid_d);
    rd_nonzero   = (rd_d != 5'd0);
  end

  // Control bits: an invalid slot or a write to x0 must never look like a live write downstream.
  always_ff @(posedge clk) begin
    if (rst || clear_e) begin
      valid_e      <= 1'b0;
      reg_write_e  <= 1'b0;
      result_src_e <= 2'b00;
      mem_write_e  <= 1'b0;
      alu_src_e    <= 1'b0;
      alu_op_e     <= 3'b000;
      branch_e     <= 1'b0;
      jump_e       <= 1'b0;
    end else if (load_e) begin
      valid_e      <= valid_d;
      reg_write_e  <= valid_d & reg_write_d & rd_nonzero;
      result_src_e <= result_src_d;
      mem_write_e  <= valid_d & mem_write_d;
      alu_src_e    <= alu_src_d;
      alu_op_e     <= alu_op_d;
      branch_e     <= valid_d & branch_d;
      jump_e       <= valid_d & jump_d;
    end
  end

  // Instruction fields, register indices, operands and PC values.
  always_ff @(posedge clk) begin
    if (rst || clear_e) begin
      funct3_e   <= 3'b000;
      funct7b5_e <= 1'b0;
      rs1_e      <= 5'd0;
      rs2_e      <= 5'd0;
      rd_e       <= 5'd0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      pc_e       <= '0;
      pc_plus4_e <= '0;
      imm_ext_e  <= '0;
    end else if (load_e) begin
      funct3_e   <= funct3_d;
      funct7b5_e <= funct7b5_d;
      rs1_e      <= rs1_d;
      rs2_e      <= rs2_d;
      rd_e       <= rd_d;
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      pc_e       <= pc_d;
      pc_plus4_e <= pc_plus4_d;
      imm_ext_e  <= imm_ext_d;
    end
  end

  // Saturating bubble counter; pinned at all-ones so a long run never wraps to a small value.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (count_bubble && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        branch;
    logic        jump;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] imm;
  } pkt_t;

  typedef struct {
    logic rst;
    logic stall;
    logic flush;
    pkt_t d;
    pkt_t exp;
    int   cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst, stall_e, flush_e;
  logic sat_rst, sat_stall, sat_flush;
  pkt_t d, e_act, e_sat;
  logic [15:0] cnt_act;
  logic [3:0]  cnt_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(d.valid), .reg_write_d(d.reg_write), .result_src_d(d.result_src),
    .mem_write_d(d.mem_write), .alu_src_d(d.alu_src), .alu_op_d(d.alu_op),
    .branch_d(d.branch), .jump_d(d.jump), .funct3_d(d.funct3), .funct7b5_d(d.funct7b5),
    .rs1_d(d.rs1), .rs2_d(d.rs2), .rd_d(d.rd), .rd1_d(d.rd1), .rd2_d(d.rd2),
    .pc_d(d.pc), .pc_plus4_d(d.pc_plus4), .imm_ext_d(d.imm),
    .valid_e(e_act.valid), .reg_write_e(e_act.reg_write), .result_src_e(e_act.result_src),
    .mem_write_e(e_act.mem_write), .alu_src_e(e_act.alu_src), .alu_op_e(e_act.alu_op),
    .branch_e(e_act.branch), .jump_e(e_act.jump), .funct3_e(e_act.funct3),
    .funct7b5_e(e_act.funct7b5), .rs1_e(e_act.rs1), .rs2_e(e_act.rs2), .rd_e(e_act.rd),
    .rd1_e(e_act.rd1), .rd2_e(e_act.rd2), .pc_e(e_act.pc), .pc_plus4_e(e_act.pc_plus4),
    .imm_ext_e(e_act.imm), .bubble_cnt(cnt_act)
  );

  id_ex_pipe_reg #(.DATA_W(32), .CNT_W(4)) u_sat (
    .clk(clk), .rst(sat_rst), .stall_e(sat_stall), .flush_e(sat_flush),
    .valid_d(d.valid), .reg_write_d(d.reg_write), .result_src_d(d.result_src),
    .mem_write_d(d.mem_write), .alu_src_d(d.alu_src), .alu_op_d(d.alu_op),
    .branch_d(d.branch), .jump_d(d.jump), .funct3_d(d.funct3), .funct7b5_d(d.funct7b5),
    .rs1_d(d.rs1), .rs2_d(d.rs2), .rd_d(d.rd), .rd1_d(d.rd1), .rd2_d(d.rd2),
    .pc_d(d.pc), .pc_plus4_d(d.pc_plus4), .imm_ext_d(d.imm),
    .valid_e(e_sat.valid), .reg_write_e(e_sat.reg_write), .result_src_e(e_sat.result_src),
    .mem_write_e(e_sat.mem_write), .alu_src_e(e_sat.alu_src), .alu_op_e(e_sat.alu_op),
    .branch_e(e_sat.branch), .jump_e(e_sat.jump), .funct3_e(e_sat.funct3),
    .funct7b5_e(e_sat.funct7b5), .rs1_e(e_sat.rs1), .rs2_e(e_sat.rs2), .rd_e(e_sat.rd),
    .rd1_e(e_sat.rd1), .rd2_e(e_sat.rd2), .pc_e(e_sat.pc), .pc_plus4_e(e_sat.pc_plus4),
    .imm_ext_e(e_sat.imm), .bubble_cnt(cnt_sat)
  );

  task automatic chk_pkt(input string nm, input pkt_t act, input pkt_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic pkt_t rand_pkt();
    logic [191:0] r;
    pkt_t p;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    p = pkt_t'(r[189:0]);
    p.valid = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 3) == 0) p.rd = 5'd0;
    return p;
  endfunction

  vec_t tbl[12];
  pkt_t p, q, sw_p, add_p, exp_e;
  int   exp_cnt;

  initial begin
    // Directed table, applied back to back from power-up.
    p = '1;
    tbl[0] = '{1'b1, 1'b0, 1'b0, p, pkt_t'(0), 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, p, pkt_t'(0), 0};

    // add x5,x6,x7
    p = '0; p.valid = 1; p.reg_write = 1; p.rs1 = 6; p.rs2 = 7; p.rd = 5;
    p.rd1 = 32'h10; p.rd2 = 32'h20; p.pc = 32'h100; p.pc_plus4 = 32'h104;
    add_p = p;
    tbl[2] = '{1'b0, 1'b0, 1'b0, p, p, 0};

    // sw x3,8(x2)
    p = '0; p.valid = 1; p.mem_write = 1; p.alu_src = 1; p.funct3 = 3'b010;
    p.rs1 = 2; p.rs2 = 3; p.rd1 = 32'h2000; p.rd2 = 32'hdeadbeef; p.imm = 32'h8;
    p.pc = 32'h104; p.pc_plus4 = 32'h108;
    sw_p = p;
    tbl[3] = '{1'b0, 1'b0, 1'b0, p, p, 0};

    // three stall cycles with changing decode contents; one has an invalid slot
    for (int k = 0; k < 3; k++) begin
      q = '1; q.rd = 5'(k + 9); q.rd1 = 32'(k * 32'h1111); q.valid = (k != 1);
      tbl[4 + k] = '{1'b0, 1'b1, 1'b0, q, sw_p, 0};
    end

    // stall and flush together with a valid jal x1 in decode
    p = '0; p.valid = 1; p.reg_write = 1; p.jump = 1; p.rd = 1; p.result_src = 2'b10;
    p.pc = 32'h200; p.pc_plus4 = 32'h204; p.imm = 32'h40;
    tbl[7] = '{1'b0, 1'b1, 1'b1, p, pkt_t'(0), 1};

    // addi x0,x1,4
    p = '0; p.valid = 1; p.reg_write = 1; p.alu_src = 1; p.rs1 = 1; p.rd = 0; p.imm = 32'h4;
    p.pc = 32'h300; p.pc_plus4 = 32'h304;
    q = p; q.reg_write = 0;
    tbl[8] = '{1'b0, 1'b0, 1'b0, p, q, 1};

    // invalid slot with every enable set: data copies, enables cleared, counts a bubble
    p = '1; p.valid = 0; p.rd = 3;
    q = p; q.reg_write = 0; q.mem_write = 0; q.branch = 0; q.jump = 0;
    tbl[9] = '{1'b0, 1'b0, 1'b0, p, q, 2};

    // reset during a flush wins, then the following edge is normal
    p = '1;
    tbl[10] = '{1'b1, 1'b0, 1'b1, p, pkt_t'(0), 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, add_p, add_p, 0};

    sat_rst = 1; sat_stall = 0; sat_flush = 0;
    rst = 1; stall_e = 0; flush_e = 0; d = '1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; stall_e = tbl[i].stall; flush_e = tbl[i].flush; d = tbl[i].d;
      @(posedge clk); #1;
      chk_pkt($sformatf("vec%0d_e", i), e_act, tbl[i].exp);
      chk_cnt($sformatf("vec%0d_cnt", i), int'(cnt_act), tbl[i].cnt);
    end

    // Randomized traffic against a reference that applies the edge rules to whole records.
    exp_e = add_p; exp_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 49) == 0);
      stall_e = ($urandom_range(0, 3) == 0);
      flush_e = ($urandom_range(0, 6) == 0);
      d       = rand_pkt();
      if (rst) begin
        exp_e = '0; exp_cnt = 0;
      end else if (flush_e) begin
        exp_e = '0; exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : exp_cnt;
      end else if (!stall_e) begin
        exp_e = d;
        if (!d.valid) begin
          exp_e.reg_write = 0; exp_e.mem_write = 0; exp_e.branch = 0; exp_e.jump = 0;
          exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : exp_cnt;
        end
        if (d.rd == 5'd0) exp_e.reg_write = 0;
      end
      @(posedge clk); #1;
      chk_pkt($sformatf("rnd%0d_e", i), e_act, exp_e);
      chk_cnt($sformatf("rnd%0d_cnt", i), int'(cnt_act), exp_cnt);
    end

    // Saturation on the 4-bit counter instance.
    @(negedge clk);
    rst = 0; stall_e = 1; flush_e = 0; d = '1;
    sat_rst = 1;
    @(posedge clk); #1;
    chk_cnt("sat_reset_cnt", int'(cnt_sat), 0);
    chk_pkt("sat_reset_e", e_sat, pkt_t'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sat_rst = 0; sat_flush = 1; sat_stall = (i % 3 == 0);
      @(posedge clk); #1;
      chk_cnt($sformatf("sat_flush%0d", i), int'(cnt_sat), (i + 1 < 15) ? i + 1 : 15);
    end
    chk_pkt("sat_bubble_e", e_sat, pkt_t'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sat_flush = 0; sat_stall = (i < 2); d.valid = 0;
      @(posedge clk); #1;
      chk_cnt($sformatf("sat_hold%0d", i), int'(cnt_sat), 15);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
